bnn_frame_loader: RTL

- Front-end stage for the rolled BNN classifier core.
- Accepts a raw sensor stream, one feature per valid/ready beat, and quantizes each sample to FEAT_BITS.
- Packs the samples into the flat feature vector that the core consumes, holds it stable for the core's settle time, then captures the core's prediction and offers it on a valid/ready result port.
- A shadow buffer lets the next frame fill while the current frame is being classified.

---
 rtl/bnn_frame_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bnn_frame_loader.sv
// Front-end stage for the rolled BNN core: packs quantized samples into a
// feature vector, holds it while the core settles, returns the prediction.
// Optional macro BNN_LOADER_ROUND_EN selects round-to-nearest quantization.
module bnn_frame_loader #(
    parameter int FEAT_CNT      = 12,
    parameter int FEAT_BITS     = 4,
    parameter int RAW_BITS      = 8,
    parameter int CLASS_CNT     = 6,
    parameter int SETTLE_CYCLES = 48
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [RAW_BITS-1:0]           in_data,
    input  logic                          in_last,
    output logic [FEAT_CNT*FEAT_BITS-1:0] features,
    input  logic [$clog2(CLASS_CNT)-1:0]  bnn_prediction,
    output logic                          pred_valid,
    input  logic                          pred_ready,
    output logic [$clog2(CLASS_CNT)-1:0]  prediction,
    output logic                          frame_err
);

    localparam int FV_W  = FEAT_CNT * FEAT_BITS;
    localparam int IDX_W = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int SHIFT = RAW_BITS - FEAT_BITS;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [FV_W-1:0]      shadow;
    logic [IDX_W-1:0]     idx;
    logic                 shadow_full;
    logic [CNT_W-1:0]     cnt;
    logic [FEAT_BITS-1:0] q;
    logic                 accept;
    logic                 is_end;
    logic                 load;
    logic                 capture;

    assign in_ready = !shadow_full;
    assign accept   = in_valid && in_ready;
    assign is_end   = (idx == IDX_W'(FEAT_CNT - 1));

`ifdef BNN_LOADER_ROUND_EN
    localparam logic [RAW_BITS:0] HALF =
        (RAW_BITS + 1)'(1) << (SHIFT - 1);

    logic [RAW_BITS:0] rnd_sum;
    logic              unused_rnd;

    // Round half up; a carry out of RAW_BITS saturates to full scale
    always_comb begin
        rnd_sum = {1'b0, in_data} + HALF;
        if (rnd_sum[RAW_BITS])
            q = '1;
        else
            q = rnd_sum[RAW_BITS-1 -: FEAT_BITS];
    end

    assign unused_rnd = ^rnd_sum[SHIFT-1:0];
`else
    logic unused_low;

    // Plain truncation: keep the top FEAT_BITS of the sample
    always_comb begin
        q = in_data[RAW_BITS-1 -: FEAT_BITS];
    end

    assign unused_low = ^in_data[SHIFT-1:0];
`endif

    // Sequencer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= FILL;
        else
            state_q <= state_d;
    end

    // Next state plus load/capture strobes
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            FILL: begin
                if (shadow_full) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(1)) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (pred_ready) begin
                    load    = shadow_full;
                    state_d = shadow_full ? RUN : FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Beat packing into the shadow buffer with framing checks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow      <= '0;
            idx         <= '0;
            shadow_full <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (load)
                shadow_full <= 1'b0;
            if (accept) begin
                if (in_last != is_end) begin
                    frame_err <= 1'b1;
                    shadow    <= '0;
                    idx       <= '0;
                end else begin
                    shadow[idx*FEAT_BITS +: FEAT_BITS] <= q;
                    if (is_end) begin
                        idx         <= '0;
                        shadow_full <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
            end
        end
    end

    // Feature load, settle countdown and result hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            features   <= '0;
            cnt        <= '0;
            prediction <= '0;
            pred_valid <= 1'b0;
        end else begin
            if (load) begin
                features <= shadow;
                cnt      <= CNT_W'(SETTLE_CYCLES);
            end else if (state_q == RUN) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (capture) begin
                prediction <= bnn_prediction;
                pred_valid <= 1'b1;
            end else if (state_q == DONE && pred_ready) begin
                pred_valid <= 1'b0;
            end
        end
    end

endmodule
